mod_period_detector: RTL

- Receive-side counterpart of the modulation generator.
- Samples an external or looped-back modulation square wave and measures its half-period in clock cycles.
- Converts the measurement to mod_half_period units, tracks lock, and flags signal loss.
- Used as an on-board loopback checker and for slaving a second board's modulation to a received envelope.

---
 rtl/mod_period_detector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mod_period_detector.sv
// Measures the half-period of a (possibly asynchronous) modulation square wave in clock
// cycles, converts it to half-period units, tracks lock and flags loss of signal.
module mod_period_detector #(
   parameter int WIDTH         = 16,
   parameter int PRESCALE_LOG2 = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int LOCK_COUNT    = 3,
   parameter int TOL           = 1,
   parameter int TIMEOUT       = 65535
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           mod_in,
   input  logic                           enable,
   output logic                           mod_level,
   output logic [WIDTH+PRESCALE_LOG2-1:0] half_period_cycles,
   output logic [WIDTH-1:0]               half_period,
   output logic                           meas_valid,
   output logic                           locked,
   output logic                           lost,
   output logic [1:0]                     state_dbg
);

   localparam int CW = WIDTH + PRESCALE_LOG2;
   localparam logic [CW-1:0] ONE_C     = CW'(1);
   localparam logic [CW-1:0] TOL_C     = CW'(TOL);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [3:0]    LOCK_C    = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      TRACK = 2'd2
   } state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_d;
   logic                   edge_q;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          diff;
   logic                   in_tol;
   logic                   timeout_hit;
   logic [3:0]             match_cnt, match_n;
   logic                   cap;
   logic                   lost_n;

   // Synchronizer and edge-history flops idle high, matching the idle level of mod_in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '1;
         level_d <= 1'b1;
         edge_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], mod_in};
         level_d <= sync_q[SYNC_STAGES-1];
         edge_q  <= sync_q[SYNC_STAGES-1] ^ level_d;
      end
   end

   assign mod_level = sync_q[SYNC_STAGES-1];

   // Value seen on an edge cycle is the number of cycles since the previous edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!enable) begin
         cnt <= '0;
      end else if (edge_q) begin
         cnt <= ONE_C;
      end else if (cnt != '1) begin
         cnt <= cnt + ONE_C;
      end
   end

   assign diff        = (cnt >= half_period_cycles) ? (cnt - half_period_cycles)
                                                    : (half_period_cycles - cnt);
   assign in_tol      = (diff <= TOL_C);
   assign timeout_hit = (cnt == TIMEOUT_C);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // An edge always takes priority over a timeout landing on the same cycle.
   always_comb begin
      state_n = state;
      match_n = match_cnt;
      cap     = 1'b0;
      lost_n  = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         match_n = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (edge_q) state_n = ARMED;
            end
            ARMED: begin
               if (edge_q) begin
                  cap     = 1'b1;
                  match_n = 4'd1;
                  state_n = TRACK;
               end else if (timeout_hit) begin
                  lost_n  = 1'b1;
                  match_n = 4'd0;
                  state_n = IDLE;
               end
            end
            TRACK: begin
               if (edge_q) begin
                  cap = 1'b1;
                  if (!in_tol)                match_n = 4'd1;
                  else if (match_cnt < LOCK_C) match_n = match_cnt + 4'd1;
                  else                         match_n = LOCK_C;
               end else if (timeout_hit) begin
                  lost_n  = 1'b1;
                  match_n = 4'd0;
                  state_n = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
               match_n = 4'd0;
            end
         endcase
      end
   end

   // meas_valid is a one-cycle strobe with no back-pressure: half_period_cycles and
   // half_period carry the new measurement in the same cycle it is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_cnt          <= 4'd0;
         meas_valid         <= 1'b0;
         lost               <= 1'b0;
         half_period_cycles <= '0;
      end else begin
         match_cnt  <= match_n;
         meas_valid <= cap;
         lost       <= lost_n;
         if (!enable) begin
            half_period_cycles <= '0;
         end else if (cap) begin
            half_period_cycles <= cnt;
         end
      end
   end

   assign locked      = (match_cnt >= LOCK_C);
   assign half_period = half_period_cycles[CW-1:PRESCALE_LOG2];
   assign state_dbg   = state;

endmodule
